enemy_bomb: RTL

- Downward-travelling counterpart of the player shot: a pool of enemy bombs spawned at the enemy position that fall toward the player row.
- Each bomb advances once per frame. A bomb is removed when it reaches the bottom of the screen or overlaps the player hitbox.
- Reports player hits to the game-state logic.
- Sits beside the player projectile logic, driven by the same clock and frame tick.

---
 rtl/game_pkg.sv | 19 +
 rtl/enemy_bomb_slot.sv | 83 ++++++++
 rtl/enemy_bomb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared screen, player-hitbox and projectile geometry for the playfield logic.
package game_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int BOTTOM_Y = 476;

    localparam int PLAYER_Y = 448;
    localparam int PLAYER_W = 32;
    localparam int PLAYER_H = 16;

    localparam int BOMB_W   = 4;
    localparam int BOMB_H   = 8;

    // Stored screen coordinate, and the widened form used for sums/compares
    typedef logic [9:0]  coord_t;
    typedef logic [10:0] coord_ext_t;

endpackage

// File: rtl/enemy_bomb_slot.sv
// One enemy bomb slot: holds position and valid flag, falls once per frame,
// despawns near the bottom edge and reports a collision with the player hitbox.
module bomb_slot
    import game_pkg::*;
#(
    parameter int SPEED    = 4,
    parameter int BOTTOM_Y = game_pkg::BOTTOM_Y,
    parameter int PLAYER_Y = game_pkg::PLAYER_Y,
    parameter int PLAYER_W = game_pkg::PLAYER_W,
    parameter int PLAYER_H = game_pkg::PLAYER_H,
    parameter int BOMB_W   = game_pkg::BOMB_W,
    parameter int BOMB_H   = game_pkg::BOMB_H
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   frame_tick,
    input  logic   i_spawn,
    input  coord_t i_spawn_x,
    input  coord_t i_spawn_y,
    input  coord_t i_playerx,
    output coord_t o_x,
    output coord_t o_y,
    output logic   o_exists,
    output logic   o_hit,
    output logic   o_free
);

    coord_t     r_x;
    coord_t     r_y;
    logic       r_exists;

    coord_ext_t w_x_ext;
    coord_ext_t w_px_ext;
    coord_ext_t w_y_moved;
    logic       w_despawn;
    logic       w_overlap;
    logic       w_collide;

    // Geometry of the move for this frame, all at 11 bits so sums never wrap
    always_comb begin
        w_x_ext   = {1'b0, r_x};
        w_px_ext  = {1'b0, i_playerx};
        w_y_moved = {1'b0, r_y} + coord_ext_t'(SPEED);
        w_despawn = r_exists && ({1'b0, r_y} >= coord_ext_t'(BOTTOM_Y - SPEED));
        w_overlap = (w_x_ext + coord_ext_t'(BOMB_W) > w_px_ext) &&
                    (w_x_ext < w_px_ext + coord_ext_t'(PLAYER_W)) &&
                    (w_y_moved + coord_ext_t'(BOMB_H) > coord_ext_t'(PLAYER_Y)) &&
                    (w_y_moved < coord_ext_t'(PLAYER_Y + PLAYER_H));
        w_collide = r_exists && !w_despawn && w_overlap;
    end

    // Slot state: spawn takes priority; otherwise despawn, or move then collide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_exists <= 1'b0;
        end else if (frame_tick) begin
            if (i_spawn) begin
                r_x      <= i_spawn_x;
                r_y      <= i_spawn_y;
                r_exists <= 1'b1;
            end else if (r_exists) begin
                if (w_despawn) begin
                    r_exists <= 1'b0;
                end else begin
                    r_y <= w_y_moved[9:0];
                    if (w_overlap) begin
                        r_exists <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_exists = r_exists;
    assign o_hit    = frame_tick && w_collide;
    // A slot vacated this frame is already usable by this frame's spawn
    assign o_free   = !r_exists || w_despawn || w_collide;

endmodule

// File: rtl/enemy_bomb.sv
// Enemy bomb pool: drop-request latch, lowest-free-slot allocator, spawn
// cooldown and a one-cycle player-hit pulse over NUM_BOMBS falling slots.
module enemy_bomb
    import game_pkg::*;
#(
    parameter int NUM_BOMBS = 4,
    parameter int SPEED     = 4,
    parameter int COOLDOWN  = 60,
    parameter int ENEMY_H   = 16,
    parameter int BOTTOM_Y  = game_pkg::BOTTOM_Y,
    parameter int PLAYER_Y  = game_pkg::PLAYER_Y,
    parameter int PLAYER_W  = game_pkg::PLAYER_W,
    parameter int PLAYER_H  = game_pkg::PLAYER_H,
    parameter int BOMB_W    = game_pkg::BOMB_W,
    parameter int BOMB_H    = game_pkg::BOMB_H
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic                     drop,
    input  logic                     enemy_alive,
    input  logic [9:0]               enemy_x,
    input  logic [9:0]               enemy_y,
    input  logic [9:0]               playerx,
    output logic [10*NUM_BOMBS-1:0]  bomb_x,
    output logic [10*NUM_BOMBS-1:0]  bomb_y,
    output logic [NUM_BOMBS-1:0]     bomb_exists,
    output logic                     player_hit,
    output logic                     drop_ready
);

    localparam int CD_W = $clog2(COOLDOWN + 1);

    logic                 r_pending;
    logic [CD_W-1:0]      r_cooldown;
    logic                 r_player_hit;

    logic [NUM_BOMBS-1:0] w_free;
    logic [NUM_BOMBS-1:0] w_hit;
    logic [NUM_BOMBS-1:0] w_spawn_sel;
    logic                 w_found;
    logic                 w_pending_now;
    logic                 w_spawn;
    coord_t               w_spawn_y;

    // A drop arriving on the frame cycle itself is spawn-eligible that frame
    assign w_pending_now = r_pending | drop;
    assign w_spawn_y     = enemy_y + coord_t'(ENEMY_H);
    assign w_spawn       = frame_tick && w_pending_now && (r_cooldown == '0) &&
                           enemy_alive && (|w_free);

    // Priority allocator: one-hot select of the lowest-index free slot
    always_comb begin
        w_spawn_sel = '0;
        w_found     = 1'b0;
        for (int unsigned i = 0; i < NUM_BOMBS; i++) begin
            if (w_free[i] && !w_found) begin
                w_spawn_sel[i] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_BOMBS; g++) begin : g_slot
        bomb_slot #(
            .SPEED    (SPEED),
            .BOTTOM_Y (BOTTOM_Y),
            .PLAYER_Y (PLAYER_Y),
            .PLAYER_W (PLAYER_W),
            .PLAYER_H (PLAYER_H),
            .BOMB_W   (BOMB_W),
            .BOMB_H   (BOMB_H)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .frame_tick (frame_tick),
            .i_spawn    (w_spawn && w_spawn_sel[g]),
            .i_spawn_x  (enemy_x),
            .i_spawn_y  (w_spawn_y),
            .i_playerx  (playerx),
            .o_x        (bomb_x[10*g +: 10]),
            .o_y        (bomb_y[10*g +: 10]),
            .o_exists   (bomb_exists[g]),
            .o_hit      (w_hit[g]),
            .o_free     (w_free[g])
        );
    end

    // Pending drop request: set by any drop, cleared only by a spawn
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= 1'b0;
        end else if (w_spawn) begin
            r_pending <= 1'b0;
        end else if (drop) begin
            r_pending <= 1'b1;
        end
    end

    // Spawn cooldown: reload on spawn, else count down once per frame to zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cooldown <= '0;
        end else if (frame_tick) begin
            if (w_spawn) begin
                r_cooldown <= CD_W'(COOLDOWN);
            end else if (r_cooldown != '0) begin
                r_cooldown <= r_cooldown - CD_W'(1);
            end
        end
    end

    // Single hit pulse for a frame, however many slots collided
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_player_hit <= 1'b0;
        end else begin
            r_player_hit <= |w_hit;
        end
    end

    assign player_hit = r_player_hit;
    assign drop_ready = (r_cooldown == '0);

endmodule
